// File: rtl/asym_fifo_pkg.sv
// Shared types and sizing helpers for the asymmetric flush FIFO.
package asym_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } flush_st_t;

    function automatic int ratio(input int wr_w, input int rd_w);
        return rd_w / wr_w;
    endfunction

    function automatic int entries(input int depth_bits, input int wr_w);
        return depth_bits / wr_w;
    endfunction

    function automatic int ptr_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/asym_flush_fifo_if.sv
// Write-lane / read-word / flush handshake bundle for asym_flush_fifo.
// The level signal exists only when ASYM_FIFO_LEVEL_EN is defined.
interface asym_flush_fifo_if #(
    parameter int WR_W  = 4,
    parameter int RD_W  = 32,
    parameter int LVL_W = 6
);
    logic            wr;
    logic [WR_W-1:0] wr_data;
    logic            rd;
    logic [RD_W-1:0] rd_data;
    logic            vld_rd_data;
    logic            flush_req;
    logic            flush_done;
    logic            full;
    logic            empty;
    logic            wr_ovf;
`ifdef ASYM_FIFO_LEVEL_EN
    logic [LVL_W-1:0] level;
`endif

    modport master (
        output wr, wr_data, rd, flush_req,
`ifdef ASYM_FIFO_LEVEL_EN
        input  level,
`endif
        input  rd_data, vld_rd_data, flush_done, full, empty, wr_ovf
    );

    modport slave (
        input  wr, wr_data, rd, flush_req,
`ifdef ASYM_FIFO_LEVEL_EN
        output level,
`endif
        output rd_data, vld_rd_data, flush_done, full, empty, wr_ovf
    );
endinterface

// File: rtl/asym_fifo_mem.sv
// N x WR_W storage: one write port, R combinational read lanes starting at rbase.
module asym_fifo_mem #(
    parameter int WR_W = 4,
    parameter int N    = 32,
    parameter int R    = 8,
    parameter int AW   = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WR_W-1:0]   wdata,
    input  logic [AW-1:0]     rbase,
    output logic [R*WR_W-1:0] rlanes
);
    logic [WR_W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Address arithmetic wraps at AW bits, so a word spanning the end gathers modulo N.
    for (genvar i = 0; i < R; i++) begin : g_lane
        logic [AW-1:0] idx;
        assign idx = rbase + AW'(i);
        assign rlanes[i*WR_W +: WR_W] = mem_q[idx];
    end
endmodule

// File: rtl/asym_flush_fifo.sv
// Narrow-write / wide-read FIFO with a flush that drains a partial final word.
// Optional ASYM_FIFO_LEVEL_EN adds a level output equal to the occupancy count.
module asym_flush_fifo
    import asym_fifo_pkg::*;
#(
    parameter int WR_W       = 4,
    parameter int RD_W       = 32,
    parameter int DEPTH_BITS = 128
) (
    input  logic               clk,
    input  logic               rst,
    asym_flush_fifo_if.slave   bus
);
    localparam int N  = entries(DEPTH_BITS, WR_W);
    localparam int R  = ratio(WR_W, RD_W);
    localparam int PW = ptr_w(N);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] R_P = PW'(R);
    localparam logic [PW-1:0] N_P = PW'(N);

    flush_st_t       st_q, st_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   mark_q, mark_d;
    logic            wr_ovf_q, wr_ovf_d;
    logic [PW-1:0]   count, flush_left, rd_adv;
    logic            wr_acc, rd_acc;
    logic [RD_W-1:0] lanes;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign flush_left = mark_q - rd_ptr_q;

    assign bus.full        = (count == N_P);
    assign bus.empty       = (count == '0);
    assign bus.vld_rd_data = (count >= R_P) || (st_q == FLUSH && flush_left != '0);
    assign bus.flush_done  = (st_q == DONE);
    assign bus.wr_ovf      = wr_ovf_q;
`ifdef ASYM_FIFO_LEVEL_EN
    assign bus.level       = count;
`endif

    // Only the final flushed word may be short; every other read takes R lanes.
    assign rd_adv = (st_q == FLUSH && flush_left < R_P) ? flush_left : R_P;
    assign wr_acc = bus.wr && !bus.full;
    assign rd_acc = bus.rd && bus.vld_rd_data;

    asym_fifo_mem #(
        .WR_W (WR_W),
        .N    (N),
        .R    (R),
        .AW   (AW)
    ) u_mem (
        .clk    (clk),
        .we     (wr_acc),
        .waddr  (wr_ptr_q[AW-1:0]),
        .wdata  (bus.wr_data),
        .rbase  (rd_ptr_q[AW-1:0]),
        .rlanes (lanes)
    );

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < R; i++) begin
            if (bus.vld_rd_data && PW'(i) < rd_adv)
                bus.rd_data[i*WR_W +: WR_W] = lanes[i*WR_W +: WR_W];
        end
    end

    always_comb begin
        st_d     = st_q;
        mark_d   = mark_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + rd_adv : rd_ptr_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + PW'(1) : wr_ptr_q;
        wr_ovf_d = bus.wr && bus.full;
        case (st_q)
            IDLE: begin
                // The mark includes a write accepted in the request cycle, nothing later.
                if (bus.flush_req) begin
                    mark_d = wr_ptr_d;
                    st_d   = (wr_ptr_d == rd_ptr_d) ? DONE : FLUSH;
                end
            end
            FLUSH:   if (rd_ptr_d == mark_q) st_d = DONE;
            DONE:    st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q     <= IDLE;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            mark_q   <= '0;
            wr_ovf_q <= 1'b0;
        end else begin
            st_q     <= st_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mark_q   <= mark_d;
            wr_ovf_q <= wr_ovf_d;
        end
    end
endmodule

// File: doc/asym_flush_fifo.md
ASYM_FLUSH_FIFO -- requirements
Module: asym_flush_fifo

Interface
REQ-001 SHALL have parameter WR_W, default 4, write-lane width in bits.
REQ-002 SHALL have parameter RD_W, default 32, read-word width; R = RD_W/WR_W SHALL be a power of two >= 2.
REQ-003 SHALL have parameter DEPTH_BITS, default 128, exact storage capacity; N = DEPTH_BITS/WR_W entries; DEPTH_BITS SHALL be a multiple of RD_W.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port wr  input  1  write-lane valid.
REQ-007 SHALL have port wr_data  input  WR_W  write lane.
REQ-008 SHALL have port rd  input  1  read strobe; consumes one word.
REQ-009 SHALL have port rd_data  output  RD_W  read word, combinational in the rd cycle.
REQ-010 SHALL have port vld_rd_data  output  1  a read may be issued.
REQ-011 SHALL have port flush_req  input  1  flush request, level, held until flush_done.
REQ-012 SHALL have port flush_done  output  1  flush complete, one-cycle pulse.
REQ-013 SHALL have port full  output  1  count == N.
REQ-014 SHALL have port empty  output  1  count == 0.
REQ-015 SHALL have port wr_ovf  output  1  one-cycle pulse: write dropped because full.

Function
REQ-016 SHALL store entries in write order in a circular buffer with rd_ptr and wr_ptr of clog2(N)+1 bits; count = wr_ptr - rd_ptr, modulo 2^(clog2(N)+1).
REQ-017 SHALL accept wr when !full, advancing wr_ptr by 1; wr when full SHALL be dropped and SHALL pulse wr_ovf the next cycle.
REQ-018 SHALL place the oldest entry in rd_data[WR_W-1:0], ascending; lanes beyond the available data SHALL read 0.
REQ-019 SHALL drive vld_rd_data = (count >= R) or (FSM == FLUSH and rd_ptr != mark).
REQ-020 SHALL, on rd with vld_rd_data, advance rd_ptr by R outside FLUSH; in FLUSH by min(R, mark - rd_ptr).
REQ-021 SHALL ignore rd while vld_rd_data is low: pointers unchanged, rd_data = 0.
REQ-022 SHALL have FSM states IDLE, FLUSH and DONE.
REQ-023 IDLE -> FLUSH on flush_req high: mark = wr_ptr plus 1 if a write is accepted that cycle; if the resulting mark equals rd_ptr after any same-cycle read, IDLE -> DONE.
REQ-024 FLUSH -> DONE in the cycle where rd_ptr reaches mark; writes after the request cycle SHALL NOT be included in the flush.
REQ-025 DONE SHALL assert flush_done for exactly one cycle, then return to IDLE; flush_req high in DONE SHALL be ignored; flush_req high in the following IDLE cycle SHALL start a new flush.
REQ-026 Writes and full reads SHALL continue during FLUSH; a same-cycle wr and rd SHALL update both pointers.
REQ-027 Pointer wrap SHALL be seamless; a read word spanning the buffer end SHALL gather lanes modulo N.

Reset
REQ-028 SHALL, on rst low at a clock edge, clear rd_ptr, wr_ptr and mark, enter IDLE, and drive empty=1, full=0, vld_rd_data=0, flush_done=0, wr_ovf=0, rd_data=0; storage contents need not be cleared.
REQ-029 SHALL abandon an in-progress flush on reset without a flush_done pulse.

Configuration
REQ-030 SHALL, with macro ASYM_FIFO_LEVEL_EN defined, add output level [clog2(N):0] = count, registered with the pointers; without the macro the port SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-031 SHALL take the FSM state enum flush_st_t and the ratio/width helper functions from package asym_fifo_pkg.
REQ-032 SHALL instantiate a single storage sub-module asym_fifo_mem: N x WR_W array, one write port, R combinational read lanes indexed from rd_ptr.

Verification (defaults WR_W=4, RD_W=32, DEPTH_BITS=128)
REQ-033 SHALL cover: write 8 nibbles 0x1..0x8, then rd -> rd_data=0x87654321, empty=1.
REQ-034 SHALL cover: write 32 nibbles -> full=1; a 33rd write -> dropped, wr_ovf pulses; 4 reads return the data in order.
REQ-035 SHALL cover: write 0xA,0xB,0xC with flush_req rising on the 0xC write cycle -> one read returns 0x00000CBA, flush_done the next cycle.
REQ-036 SHALL cover: 3 nibbles stored, flush asserted, writes continue during FLUSH -> flushed word has only the 3 nibbles; later data is readable after 8 further nibbles.
REQ-037 SHALL cover: pointers wrapped past N, then a read word straddling the buffer end -> correct lane order.
REQ-038 SHALL cover: rst low during FLUSH -> all outputs at reset values next cycle, no flush_done.
